// File: rtl/photonic_gate_pkg.sv
// Shared types and defaults for the photonic switch gate timing generator.
package photonic_gate_pkg;

  localparam int CNT_W_DEF   = 7;
  localparam int HOLDOFF_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_HOLDOFF = 2'd3
  } gate_state_e;

endpackage

// File: rtl/photonic_gate_gen_trig_edge_det.sv
// Rising-edge detector: registered previous level, combinational one-cycle rise.
module trig_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic trig_i,
  output logic rise_o
);

  logic trig_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trig_prev_q <= 1'b0;
    end else begin
      trig_prev_q <= trig_i;
    end
  end

  assign rise_o = trig_i & ~trig_prev_q;

endmodule

// File: rtl/photonic_gate_gen.sv
// Gate timing generator: trigger edge -> programmed delay -> gate pulse -> holdoff.
// Optional PHOTONIC_GATE_RETRIG_EN: a trigger level still high at holdoff exit re-arms directly.
module photonic_gate_gen
  import photonic_gate_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int HOLDOFF = HOLDOFF_DEF
) (
  input  logic             counter_clk,
  input  logic             reset_n,
  input  logic             trig,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0] width_cfg,
  output logic [CNT_W-1:0] count,
  output logic             gate,
  output logic             done,
  output logic             busy,
  output logic             retrig_err
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  gate_state_e      state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] delay_q;
  logic [CNT_W-1:0] width_q;
  logic             gate_q;
  logic             done_q;
  logic             retrig_err_q;
  logic             trig_rise;
  logic [CNT_W-1:0] width_last;

  trig_edge_det u_trig_edge_det (
    .clk_i  (counter_clk),
    .rst_ni (reset_n),
    .trig_i (trig),
    .rise_o (trig_rise)
  );

  // A zero width is treated as one cycle, so the last active count is 0.
  assign width_last = (width_q == '0) ? '0 : (width_q - CNT_ONE);

  always_ff @(posedge counter_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      delay_q      <= '0;
      width_q      <= '0;
      gate_q       <= 1'b0;
      done_q       <= 1'b0;
      retrig_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (trig_rise && (state_q != ST_IDLE)) begin
        retrig_err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (cfg_load) begin
            delay_q      <= delay_cfg;
            width_q      <= width_cfg;
            retrig_err_q <= 1'b0;
          end
          if (trig_rise) begin
            state_q <= ST_DELAY;
            count_q <= '0;
          end
        end
        ST_DELAY: begin
          if (count_q == delay_q) begin
            state_q <= ST_ACTIVE;
            count_q <= '0;
            gate_q  <= 1'b1;
          end else begin
            count_q <= count_q + CNT_ONE;
          end
        end
        ST_ACTIVE: begin
          if (count_q == width_last) begin
            state_q <= ST_HOLDOFF;
            count_q <= '0;
            gate_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            count_q <= count_q + CNT_ONE;
          end
        end
        ST_HOLDOFF: begin
          if (count_q == HOLD_LAST) begin
            count_q <= '0;
`ifdef PHOTONIC_GATE_RETRIG_EN
            state_q <= trig ? ST_DELAY : ST_IDLE;
`else
            state_q <= ST_IDLE;
`endif
          end else begin
            count_q <= count_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          count_q <= '0;
          gate_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count      = count_q;
  assign gate       = gate_q;
  assign done       = done_q;
  assign busy       = (state_q != ST_IDLE);
  assign retrig_err = retrig_err_q;

endmodule

// File: tb/tb_photonic_gate_gen.sv
// Directed bench for photonic_gate_gen: pulse timing, zero/max fields, retrigger, cfg while busy, async reset.
module tb_photonic_gate_gen;

  localparam int CNT_W   = 7;
  localparam int HOLDOFF = 2;

  logic             counter_clk = 1'b0;
  logic             reset_n;
  logic             trig;
  logic             cfg_load;
  logic [CNT_W-1:0] delay_cfg;
  logic [CNT_W-1:0] width_cfg;
  logic [CNT_W-1:0] count;
  logic             gate;
  logic             done;
  logic             busy;
  logic             retrig_err;

  int n_checks = 0;
  int n_errors = 0;
  int max_cnt  = 0;

  photonic_gate_gen #(.CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) dut (
    .counter_clk (counter_clk),
    .reset_n     (reset_n),
    .trig        (trig),
    .cfg_load    (cfg_load),
    .delay_cfg   (delay_cfg),
    .width_cfg   (width_cfg),
    .count       (count),
    .gate        (gate),
    .done        (done),
    .busy        (busy),
    .retrig_err  (retrig_err)
  );

  always #5 counter_clk = ~counter_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge, return on the following falling edge.
  task automatic tick();
    @(posedge counter_clk);
    @(negedge counter_clk);
  endtask

  task automatic load_cfg(input int d, input int w);
    cfg_load  = 1'b1;
    delay_cfg = CNT_W'(d);
    width_cfg = CNT_W'(w);
    tick();
    cfg_load  = 1'b0;
  endtask

  // Raise trig (edge T is k=0) and check every cycle until one past return to idle.
  // rk>0: re-raise trig so a second rising edge lands on edge T+rk.
  // ck>=0: pulse cfg_load (delay 10, width 9) at the edge T+ck+1.
  task automatic run_pulse(input string tag, input int d, input int w, input int rk, input int ck);
    int last;
    int ecnt;
    last    = d + w + HOLDOFF + 1;
    max_cnt = 0;
    trig    = 1'b1;
    tick();
    for (int k = 0; k <= last + 1; k++) begin
      if (k > 0) tick();
      if (k == 0)                 ecnt = 0;
      else if (k <= d)            ecnt = k;
      else if (k <= d + w)        ecnt = k - d - 1;
      else if (k < last)          ecnt = k - d - w - 1;
      else                        ecnt = 0;
      chk({tag, "_gate"},  32'(gate),  32'((k >= d + 1) && (k <= d + w)));
      chk({tag, "_done"},  32'(done),  32'(k == d + w + 1));
      chk({tag, "_busy"},  32'(busy),  32'(k < last));
      chk({tag, "_count"}, 32'(count), 32'(ecnt));
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (k == 0) trig = 1'b0;
      if (rk > 0 && k == rk - 1) trig = 1'b1;
      if (ck >= 0 && k == ck) begin
        cfg_load  = 1'b1;
        delay_cfg = CNT_W'(10);
        width_cfg = CNT_W'(9);
      end
      if (ck >= 0 && k == ck + 1) cfg_load = 1'b0;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    trig      = 1'b0;
    cfg_load  = 1'b0;
    delay_cfg = '0;
    width_cfg = '0;
    #3;
    chk("rst_gate",   32'(gate),       32'd0);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_count",  32'(count),      32'd0);
    chk("rst_retrig", 32'(retrig_err), 32'd0);
    @(negedge counter_clk);
    reset_n = 1'b1;
    tick();

    // Basic pulse: delay 3, width 4.
    load_cfg(3, 4);
    run_pulse("basic", 3, 4, -1, -1);
    chk("basic_retrig", 32'(retrig_err), 32'd0);

    // Zero fields: one-cycle gate one edge after trigger.
    load_cfg(0, 0);
    run_pulse("zero", 0, 1, -1, -1);

    // Second edge during ACTIVE: timing unchanged, sticky error, trig left high.
    load_cfg(3, 4);
    run_pulse("retrig", 3, 4, 6, -1);
    chk("retrig_err_set", 32'(retrig_err), 32'd1);
    repeat (3) begin
      tick();
      chk("held_no_rearm", 32'(busy),       32'd0);
      chk("retrig_sticky", 32'(retrig_err), 32'd1);
    end
    trig = 1'b0;
    tick();
    load_cfg(3, 4);
    chk("retrig_cleared", 32'(retrig_err), 32'd0);

    // cfg_load while busy is ignored for this and the next sequence.
    run_pulse("cfgbusy", 3, 4, -1, 1);
    run_pulse("cfgnext", 3, 4, -1, -1);

    // Asynchronous reset in the middle of the gate pulse.
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (5) tick();
    chk("mid_gate_pre", 32'(gate), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_gate",  32'(gate),  32'd0);
    chk("arst_busy",  32'(busy),  32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_done",  32'(done),  32'd0);
    @(negedge counter_clk);
    reset_n = 1'b1;
    repeat (4) begin
      tick();
      chk("post_rst_idle", 32'(busy), 32'd0);
      chk("post_rst_gate", 32'(gate), 32'd0);
    end

    // Maximum fields: 128 edges to gate rise, 127 high cycles.
    load_cfg(127, 127);
    run_pulse("max", 127, 127, -1, -1);
    chk("max_count_peak", 32'(max_cnt), 32'd127);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
